// File: rtl/polygon_pkg.sv
// ----------------------------------------------------------------------------
// polygon_pkg
// Shared types and constants for the polygon vertex buffer and its users.
//   coord_t                  : signed 32-bit screen coordinate
//   vbuf_state_t             : vertex buffer load-state encoding
//   DEFAULT_MAX_NUM_VERTICES : default bank depth (must match in_polygon)
// ----------------------------------------------------------------------------
package polygon_pkg;

    typedef logic signed [31:0] coord_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        COMPLETE = 2'd2
    } vbuf_state_t;

    localparam int DEFAULT_MAX_NUM_VERTICES = 32;

endpackage : polygon_pkg

// File: rtl/polygon_vertex_buffer_if.sv
// ----------------------------------------------------------------------------
// polygon_vertex_buffer_if
// Producer-to-buffer vertex stream (valid/ready handshake).
//   vertex_valid_in  : producer has a vertex
//   vertex_x_in      : vertex x (signed)
//   vertex_y_in      : vertex y (signed)
//   vertex_last_in   : final vertex of the polygon
//   vertex_ready_out : buffer accepts a vertex
// Modports: master = producer side, slave = buffer side.
// ----------------------------------------------------------------------------
interface polygon_vertex_buffer_if;
    import polygon_pkg::*;

    logic   vertex_valid_in;
    coord_t vertex_x_in;
    coord_t vertex_y_in;
    logic   vertex_last_in;
    logic   vertex_ready_out;

    modport master (
        output vertex_valid_in,
        output vertex_x_in,
        output vertex_y_in,
        output vertex_last_in,
        input  vertex_ready_out
    );

    modport slave (
        input  vertex_valid_in,
        input  vertex_x_in,
        input  vertex_y_in,
        input  vertex_last_in,
        output vertex_ready_out
    );

endinterface : polygon_vertex_buffer_if

// File: rtl/vertex_bank.sv
// ----------------------------------------------------------------------------
// vertex_bank
// One bank of DEPTH x/y coordinate registers with a single write port and a
// full parallel read-out (every entry visible every cycle).
//   clk_in, rst_n_in : clock, asynchronous active-low reset (clears entries)
//   wr_en            : write strobe
//   wr_addr          : entry index to write
//   wr_x, wr_y       : coordinate pair written
//   rd_xs, rd_ys     : all entries, in parallel
// ----------------------------------------------------------------------------
module vertex_bank
    import polygon_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_NUM_VERTICES,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  coord_t        wr_x,
    input  coord_t        wr_y,
    output coord_t        rd_xs [DEPTH],
    output coord_t        rd_ys [DEPTH]
);

    coord_t mem_x [DEPTH];
    coord_t mem_y [DEPTH];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x[i] <= '0;
                mem_y[i] <= '0;
            end
        end else if (wr_en) begin
            mem_x[wr_addr] <= wr_x;
            mem_y[wr_addr] <= wr_y;
        end
    end

    assign rd_xs = mem_x;
    assign rd_ys = mem_y;

endmodule : vertex_bank

// File: rtl/polygon_vertex_buffer.sv
// ----------------------------------------------------------------------------
// polygon_vertex_buffer
// Double-buffered vertex store feeding in_polygon. A producer streams one
// polygon into the back bank; a frame-swap pulse in COMPLETE promotes it to
// the front bank, so the front outputs only ever change at a swap edge.
//   clk_in, rst_n_in  : clock, asynchronous active-low reset
//   vtx (slave)       : vertex stream valid/ready/x/y/last
//   frame_swap_in     : one-cycle pulse at start of vertical blanking
//   xs_out, ys_out    : front bank coordinate arrays
//   num_points_out    : front vertex count
//   overflow_out      : front polygon was truncated at MAX_NUM_VERTICES
//   bbox_*_out        : front bounding box
// Build option: POLYGON_VERTEX_BUFFER_BBOX_EN enables the running bounding-box
// tracker; when undefined the bbox outputs are the full screen.
// ----------------------------------------------------------------------------
module polygon_vertex_buffer
    import polygon_pkg::*;
#(
    parameter int MAX_NUM_VERTICES = DEFAULT_MAX_NUM_VERTICES,
    parameter int PIXEL_WIDTH      = 1280,
    parameter int PIXEL_HEIGHT     = 720
) (
    input  logic                                    clk_in,
    input  logic                                    rst_n_in,
    polygon_vertex_buffer_if.slave                  vtx,
    input  logic                                    frame_swap_in,
    output coord_t                                  xs_out [MAX_NUM_VERTICES],
    output coord_t                                  ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]   num_points_out,
    output logic                                    overflow_out,
    output coord_t                                  bbox_min_x_out,
    output coord_t                                  bbox_min_y_out,
    output coord_t                                  bbox_max_x_out,
    output coord_t                                  bbox_max_y_out
);

    localparam int CNT_W = $clog2(MAX_NUM_VERTICES + 1);
    localparam int AW    = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;

    vbuf_state_t        state_q, state_d;
    logic               bank_sel_q;
    logic [CNT_W-1:0]   wr_count_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   num_points_q;
    logic               overflow_q;

    logic               ready;
    logic               accept;
    logic               wr_full;
    logic               wr_keep;
    logic               swap_go;

    coord_t             a_xs [MAX_NUM_VERTICES];
    coord_t             a_ys [MAX_NUM_VERTICES];
    coord_t             b_xs [MAX_NUM_VERTICES];
    coord_t             b_ys [MAX_NUM_VERTICES];

    // Ready depends on the state register alone, never on valid or swap.
    assign ready                = (state_q != COMPLETE);
    assign vtx.vertex_ready_out = ready;
    assign accept               = vtx.vertex_valid_in && ready;
    assign wr_full              = (wr_count_q == CNT_W'(MAX_NUM_VERTICES));
    // Vertices past the bank depth are accepted but dropped.
    assign wr_keep              = accept && !wr_full;
    // COMPLETE never accepts, so a swap and an accept are mutually exclusive.
    assign swap_go              = (state_q == COMPLETE) && frame_swap_in;

    // ---- state register ----
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // ---- next-state decode ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = vtx.vertex_last_in ? COMPLETE : LOAD;
            end
            LOAD: begin
                if (accept && vtx.vertex_last_in) state_d = COMPLETE;
            end
            COMPLETE: begin
                if (frame_swap_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- write counter, overflow and front-bank registers ----
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bank_sel_q   <= 1'b0;
            wr_count_q   <= '0;
            ovf_q        <= 1'b0;
            num_points_q <= '0;
            overflow_q   <= 1'b0;
        end else if (swap_go) begin
            bank_sel_q   <= ~bank_sel_q;
            num_points_q <= wr_count_q;
            overflow_q   <= ovf_q;
            wr_count_q   <= '0;
            ovf_q        <= 1'b0;
        end else if (accept) begin
            if (wr_full) ovf_q      <= 1'b1;
            else         wr_count_q <= wr_count_q + 1'b1;
        end
    end

    // Bank A is the back bank while bank_sel=1, bank B while bank_sel=0.
    vertex_bank #(.DEPTH(MAX_NUM_VERTICES), .AW(AW)) u_bank_a (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .wr_en    (wr_keep && bank_sel_q),
        .wr_addr  (wr_count_q[AW-1:0]),
        .wr_x     (vtx.vertex_x_in),
        .wr_y     (vtx.vertex_y_in),
        .rd_xs    (a_xs),
        .rd_ys    (a_ys)
    );

    vertex_bank #(.DEPTH(MAX_NUM_VERTICES), .AW(AW)) u_bank_b (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .wr_en    (wr_keep && !bank_sel_q),
        .wr_addr  (wr_count_q[AW-1:0]),
        .wr_x     (vtx.vertex_x_in),
        .wr_y     (vtx.vertex_y_in),
        .rd_xs    (b_xs),
        .rd_ys    (b_ys)
    );

    always_comb begin
        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
            xs_out[i] = bank_sel_q ? b_xs[i] : a_xs[i];
            ys_out[i] = bank_sel_q ? b_ys[i] : a_ys[i];
        end
    end

    assign num_points_out = num_points_q;
    assign overflow_out   = overflow_q;

`ifdef POLYGON_VERTEX_BUFFER_BBOX_EN
    function automatic coord_t smin(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t smax(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

    coord_t trk_min_x, trk_min_y, trk_max_x, trk_max_y;
    coord_t bb_min_x, bb_min_y, bb_max_x, bb_max_y;

    // ---- running bbox tracker, latched to the outputs at swap ----
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            trk_min_x <= '0;
            trk_min_y <= '0;
            trk_max_x <= '0;
            trk_max_y <= '0;
            bb_min_x  <= '0;
            bb_min_y  <= '0;
            bb_max_x  <= '0;
            bb_max_y  <= '0;
        end else if (swap_go) begin
            bb_min_x  <= trk_min_x;
            bb_min_y  <= trk_min_y;
            bb_max_x  <= trk_max_x;
            bb_max_y  <= trk_max_y;
        end else if (wr_keep) begin
            // The first stored vertex seeds the box for this polygon.
            if (wr_count_q == '0) begin
                trk_min_x <= vtx.vertex_x_in;
                trk_min_y <= vtx.vertex_y_in;
                trk_max_x <= vtx.vertex_x_in;
                trk_max_y <= vtx.vertex_y_in;
            end else begin
                trk_min_x <= smin(trk_min_x, vtx.vertex_x_in);
                trk_min_y <= smin(trk_min_y, vtx.vertex_y_in);
                trk_max_x <= smax(trk_max_x, vtx.vertex_x_in);
                trk_max_y <= smax(trk_max_y, vtx.vertex_y_in);
            end
        end
    end

    assign bbox_min_x_out = bb_min_x;
    assign bbox_min_y_out = bb_min_y;
    assign bbox_max_x_out = bb_max_x;
    assign bbox_max_y_out = bb_max_y;
`else
    assign bbox_min_x_out = '0;
    assign bbox_min_y_out = '0;
    assign bbox_max_x_out = coord_t'(PIXEL_WIDTH - 1);
    assign bbox_max_y_out = coord_t'(PIXEL_HEIGHT - 1);
`endif

endmodule : polygon_vertex_buffer
